ro_trng_controller: RTL and testbench

//  Sequences an array of NUM_RO free-running ring oscillators as a TRNG entropy source:

---
 rtl/ro_trng_controller_pkg.sv | 15 +
 rtl/ro_vn_debias.sv | 32 +++
 rtl/ro_trng_controller.sv | 132 +++++++++++++
 tb/tb_ro_trng_controller.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_trng_controller_pkg.sv
// Shared FSM encodings and counter-sizing helper for the ring-oscillator TRNG controller.
package ro_trng_controller_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_WARMUP  = 3'd1;
   localparam logic [2:0] ST_COLLECT = 3'd2;
   localparam logic [2:0] ST_HOLD    = 3'd3;
   localparam logic [2:0] ST_ERROR   = 3'd4;

   // Counter width able to hold 0..max_val; never narrower than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ro_vn_debias.sv
// Von Neumann debiaser: pairs consecutive raw samples, emits first bit of a 10/01 pair.
module ro_vn_debias
   import ro_trng_controller_pkg::*;
(
   input  logic ro_clk,
   input  logic ro_rst_n,
   input  logic raw,
   input  logic tick,
   input  logic clr,
   output logic bit_val,
   output logic bit_vld
);

   logic have_first;
   logic first;

   always_ff @(posedge ro_clk or negedge ro_rst_n) begin
      if (!ro_rst_n) begin
         have_first <= 1'b0;
         first      <= 1'b0;
      end else if (clr) begin
         have_first <= 1'b0;
      end else if (tick) begin
         have_first <= !have_first;
         if (!have_first) first <= raw;
      end
   end

   assign bit_val = first;
   assign bit_vld = tick && !clr && have_first && (first != raw);

endmodule

// File: rtl/ro_trng_controller.sv
// Ring-oscillator TRNG sequencer: warm-up, sampling, debiasing, repetition health check, word output.
//  state   | meaning
//  IDLE    | array off, waiting for enable
//  WARMUP  | array on, letting oscillators settle
//  COLLECT | sampling and packing debiased bits
//  HOLD    | full word presented, waiting for handshake
//  ERROR   | repetition check tripped, array off
module ro_trng_controller
   import ro_trng_controller_pkg::*;
#(
   parameter int NUM_RO        = 8,
   parameter int WARMUP_CYCLES = 16,
   parameter int SAMPLE_DIV    = 4,
   parameter int WORD_W        = 32,
   parameter int REP_LIMIT     = 8
) (
   input  logic              ro_clk,
   input  logic              ro_rst_n,
   input  logic              enable,
   input  logic [NUM_RO-1:0] ro_bits,
   output logic [NUM_RO-1:0] ro_en,
   output logic [WORD_W-1:0] rnd_data,
   output logic              rnd_valid,
   input  logic              rnd_ready,
   output logic              busy,
   output logic              health_err
);

   localparam int WARM_W = cnt_width(WARMUP_CYCLES);
   localparam int DIV_W  = cnt_width(SAMPLE_DIV);
   localparam int BIT_W  = cnt_width(WORD_W);
   localparam int REP_W  = cnt_width(REP_LIMIT);

   logic [NUM_RO-1:0] sync_a, sync_b;
   logic [2:0]        state, state_nxt;
   logic [WARM_W-1:0] warm_cnt;
   logic [DIV_W-1:0]  div_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [REP_W-1:0]  rep_cnt, rep_nxt;
   logic [WORD_W-1:0] word_sr;
   logic              prev_raw;
   logic              raw, tick, clr, rep_trip, word_done;
   logic              bit_val, bit_vld;

   assign raw       = ^sync_b;
   assign tick      = (state == ST_COLLECT) && enable && (div_cnt == '0);
   assign clr       = (state != ST_COLLECT);
   assign rep_nxt   = (rep_cnt != '0 && raw == prev_raw) ? rep_cnt + REP_W'(1) : REP_W'(1);
   assign rep_trip  = tick && (rep_nxt == REP_W'(REP_LIMIT));
   assign word_done = bit_vld && (bit_cnt == BIT_W'(WORD_W - 1));

   ro_vn_debias u_debias (
      .ro_clk   (ro_clk),
      .ro_rst_n (ro_rst_n),
      .raw      (raw),
      .tick     (tick),
      .clr      (clr),
      .bit_val  (bit_val),
      .bit_vld  (bit_vld)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (enable) state_nxt = ST_WARMUP;
         ST_WARMUP:  if (!enable) state_nxt = ST_IDLE;
                     else if (warm_cnt == '0) state_nxt = ST_COLLECT;
         ST_COLLECT: if (!enable) state_nxt = ST_IDLE;
                     else if (rep_trip) state_nxt = ST_ERROR;
                     else if (word_done) state_nxt = ST_HOLD;
         ST_HOLD:    if (rnd_ready) state_nxt = enable ? ST_COLLECT : ST_IDLE;
         ST_ERROR:   if (!enable) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge ro_clk or negedge ro_rst_n) begin
      if (!ro_rst_n) begin
         sync_a     <= '0;
         sync_b     <= '0;
         state      <= ST_IDLE;
         ro_en      <= '0;
         rnd_data   <= '0;
         rnd_valid  <= 1'b0;
         busy       <= 1'b0;
         health_err <= 1'b0;
         warm_cnt   <= '0;
         div_cnt    <= '0;
         bit_cnt    <= '0;
         rep_cnt    <= '0;
         word_sr    <= '0;
         prev_raw   <= 1'b0;
      end else begin
         sync_a    <= ro_bits;
         sync_b    <= sync_a;
         state     <= state_nxt;
         ro_en     <= {NUM_RO{(state_nxt == ST_WARMUP) || (state_nxt == ST_COLLECT) ||
                              (state_nxt == ST_HOLD)}};
         busy      <= (state_nxt != ST_IDLE);
         rnd_valid <= (state_nxt == ST_HOLD);

         if (state == ST_IDLE && enable) begin
            health_err <= 1'b0;
            rep_cnt    <= '0;
            warm_cnt   <= WARM_W'(WARMUP_CYCLES - 1);
         end else begin
            if (state_nxt == ST_ERROR) health_err <= 1'b1;
            if (state == ST_WARMUP && warm_cnt != '0) warm_cnt <= warm_cnt - WARM_W'(1);
            if (tick) rep_cnt <= rep_trip ? '0 : rep_nxt;
         end

         if (tick) prev_raw <= raw;

         if (tick) div_cnt <= DIV_W'(SAMPLE_DIV - 1);
         else if (state != ST_COLLECT) div_cnt <= '0;
         else if (div_cnt != '0) div_cnt <= div_cnt - DIV_W'(1);

         // LSB-first packing: after WORD_W shifts the first bit lands at index 0.
         if (state != ST_COLLECT) begin
            bit_cnt <= '0;
            word_sr <= '0;
         end else if (bit_vld) begin
            word_sr <= {bit_val, word_sr[WORD_W-1:1]};
            bit_cnt <= word_done ? '0 : bit_cnt + BIT_W'(1);
         end

         if (state == ST_COLLECT && state_nxt == ST_HOLD)
            rnd_data <= {bit_val, word_sr[WORD_W-1:1]};
      end
   end

endmodule

// File: tb/tb_ro_trng_controller.sv
// Directed bench with a sample-stream model of the TRNG controller, checked every cycle.
module tb_ro_trng_controller;

   localparam int NUM_RO = 2;
   localparam int WARMUP = 4;
   localparam int DIV    = 1;
   localparam int WORD_W = 8;
   localparam int REP    = 6;

   localparam int M_IDLE = 0, M_WARM = 1, M_COLL = 2, M_HOLD = 3, M_ERR = 4;

   logic              ro_clk = 1'b0;
   logic              ro_rst_n = 1'b1;
   logic              enable = 1'b0;
   logic [NUM_RO-1:0] ro_bits = '0;
   logic [NUM_RO-1:0] ro_en;
   logic [WORD_W-1:0] rnd_data;
   logic              rnd_valid;
   logic              rnd_ready = 1'b0;
   logic              busy;
   logic              health_err;

   int checks = 0;
   int errors = 0;

   ro_trng_controller #(
      .NUM_RO(NUM_RO), .WARMUP_CYCLES(WARMUP), .SAMPLE_DIV(DIV),
      .WORD_W(WORD_W), .REP_LIMIT(REP)
   ) dut (
      .ro_clk     (ro_clk),
      .ro_rst_n   (ro_rst_n),
      .enable     (enable),
      .ro_bits    (ro_bits),
      .ro_en      (ro_en),
      .rnd_data   (rnd_data),
      .rnd_valid  (rnd_valid),
      .rnd_ready  (rnd_ready),
      .busy       (busy),
      .health_err (health_err)
   );

   always #5 ro_clk = ~ro_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: stream of raw samples, grouped into pairs and words by plain queue arithmetic.
   int          m_mode = M_IDLE;
   int          m_elapsed = 0;
   int          m_coll_cycles = 0;
   int          m_run = 0;
   logic        m_health = 1'b0;
   logic        m_prev = 1'b0;
   logic        m_s1 = 1'b0, m_s2 = 1'b0, m_raw;
   logic        m_pend[$];
   logic        m_bits[$];
   logic [7:0]  m_word = '0;

   initial forever begin
      @(posedge ro_clk or negedge ro_rst_n);
      if (!ro_rst_n) begin
         m_mode = M_IDLE; m_health = 1'b0; m_run = 0; m_s1 = 1'b0; m_s2 = 1'b0;
         m_pend.delete(); m_bits.delete();
      end else begin
         m_raw = m_s2;
         m_s2  = m_s1;
         m_s1  = ^ro_bits;
         case (m_mode)
            M_IDLE: if (enable) begin
               m_mode = M_WARM; m_elapsed = 0; m_health = 1'b0; m_run = 0;
            end
            M_WARM: if (!enable) m_mode = M_IDLE;
               else begin
                  m_elapsed++;
                  if (m_elapsed == WARMUP) begin
                     m_mode = M_COLL; m_coll_cycles = 0; m_pend.delete(); m_bits.delete();
                  end
               end
            M_COLL: if (!enable) m_mode = M_IDLE;
               else begin
                  if (m_coll_cycles % DIV == 0) begin
                     m_run  = (m_run > 0 && m_raw == m_prev) ? m_run + 1 : 1;
                     m_prev = m_raw;
                     m_pend.push_back(m_raw);
                     if (m_pend.size() == 2) begin
                        if (m_pend[0] != m_pend[1]) m_bits.push_back(m_pend[0]);
                        m_pend.delete();
                     end
                     if (m_run == REP) begin
                        m_mode = M_ERR; m_health = 1'b1;
                     end else if (m_bits.size() == WORD_W) begin
                        for (int i = 0; i < WORD_W; i++) m_word[i] = m_bits[i];
                        m_bits.delete();
                        m_mode = M_HOLD;
                     end
                  end
                  m_coll_cycles++;
               end
            M_HOLD: if (rnd_ready) begin
               if (enable) begin
                  m_mode = M_COLL; m_coll_cycles = 0; m_pend.delete(); m_bits.delete();
               end else m_mode = M_IDLE;
            end
            default: if (!enable) m_mode = M_IDLE;
         endcase
      end
   end

   initial forever begin
      @(negedge ro_clk);
      if (ro_rst_n) begin
         check("m_ro_en", ro_en,
               (m_mode == M_WARM || m_mode == M_COLL || m_mode == M_HOLD) ? 2'b11 : 2'b00);
         check("m_busy", busy, m_mode != M_IDLE);
         check("m_valid", rnd_valid, m_mode == M_HOLD);
         check("m_health", health_err, m_health);
         if (m_mode == M_HOLD) check("m_data", rnd_data, m_word);
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge ro_clk);
         #1;
      end
   endtask

   task automatic feed(input logic [31:0] pat, input int len);
      for (int i = 0; i < len; i++) begin
         ro_bits = {1'b0, pat[i]};
         step(1);
      end
   endtask

   // After this the next fed value is the first one sampled in COLLECT.
   task automatic start_run();
      enable = 1'b1;
      step(1);
      check("start_ro_en", ro_en, 2'b11);
      check("start_busy", busy, 1'b1);
      check("start_health", health_err, 1'b0);
      step(2);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!rnd_valid && n < 30) begin
         step(1);
         n++;
      end
      check("wait_valid", rnd_valid, 1'b1);
   endtask

   initial begin
      #1 ro_rst_n = 1'b0;
      step(3);
      ro_rst_n = 1'b1;
      step(1);
      check("rst_busy", busy, 1'b0);
      check("rst_ro_en", ro_en, 2'b00);
      check("rst_valid", rnd_valid, 1'b0);
      check("rst_health", health_err, 1'b0);

      // pairs 10,01 x4 -> 0x55, then hold under back-pressure
      start_run();
      feed(32'h9999, 16);
      wait_valid();
      check("word_55", rnd_data, 8'h55);
      for (int i = 0; i < 10; i++) begin
         step(1);
         check("hold_data", rnd_data, 8'h55);
         check("hold_valid", rnd_valid, 1'b1);
      end
      rnd_ready = 1'b1;
      step(1);
      check("accept_valid", rnd_valid, 1'b0);
      rnd_ready = 1'b0;
      enable = 1'b0;
      step(1);

      // pairs 00,11 only -> nothing emitted
      start_run();
      feed(32'hCCCC, 16);
      step(2);
      check("discard_valid", rnd_valid, 1'b0);
      check("discard_health", health_err, 1'b0);
      check("discard_busy", busy, 1'b1);
      enable = 1'b0;
      step(1);

      // raw stuck at 1 for six samples
      start_run();
      feed(32'h3F, 6);
      step(2);
      check("rep_health", health_err, 1'b1);
      check("rep_ro_en", ro_en, 2'b00);
      enable = 1'b0;
      step(1);
      check("err_idle_health", health_err, 1'b1);
      check("err_idle_busy", busy, 1'b0);

      // three bits then abort; next word must start fresh
      start_run();
      feed(32'h19, 6);
      step(2);
      enable = 1'b0;
      step(1);
      check("abort_busy", busy, 1'b0);
      check("abort_ro_en", ro_en, 2'b00);
      start_run();
      feed(32'h6666, 16);
      wait_valid();
      check("word_aa", rnd_data, 8'hAA);
      rnd_ready = 1'b1;
      step(1);
      check("accept2_valid", rnd_valid, 1'b0);
      rnd_ready = 1'b0;
      enable = 1'b0;
      step(1);

      // reset in the middle of collection
      start_run();
      feed(32'h9, 4);
      ro_rst_n = 1'b0;
      #1;
      check("midrst_ro_en", ro_en, 2'b00);
      check("midrst_busy", busy, 1'b0);
      check("midrst_valid", rnd_valid, 1'b0);
      check("midrst_data", rnd_data, 8'h00);
      enable = 1'b0;
      step(2);
      ro_rst_n = 1'b1;
      step(2);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_ro_en", ro_en, 2'b00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
